serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 152 +++++++++++++++
 tb/tb_serial_adder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder
//  Description : Single-bit half adder (sum = a ^ b, carry = a & b).
//  Ports       : a, b  - input bits
//                s     - sum bit
//                c     - carry bit
//  Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. Accepts WIDTH-bit operands plus carry-in
//                on start, adds one bit per clock (LSB first) through a
//                half-adder based full adder, then presents a registered
//                sum/cout with a one-cycle done pulse.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset
//                start  - add request, sampled only in IDLE
//                a, b   - operands, captured on accepted start
//                cin    - carry-in, captured on accepted start
//                busy   - high while the add is in progress
//                done   - one-cycle pulse marking a valid result
//                sum    - registered result (low WIDTH bits)
//                cout   - registered carry-out (bit WIDTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Full adder on the current LSBs: two half adders, carries ORed
  logic ha0_s, ha0_c, ha1_s, ha1_c, fa_s, fa_c;

  half_adder u_ha0 (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .a (ha0_s),
    .b (carry),
    .s (ha1_s),
    .c (ha1_c)
  );

  assign fa_s = ha1_s;
  assign fa_c = ha0_c | ha1_c;

  // Result register after this cycle's bit is shifted in from the MSB side;
  // on the final bit this is the complete sum.
  logic [WIDTH-1:0] res_next;
  assign res_next = {fa_s, res_sh[WIDTH-1:1]};

  // Next-state and output decode
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            res_sh <= '0;
            cnt    <= '0;
          end
        end
        ADD: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_next;
          carry  <= fa_c;
          cnt    <= cnt + CNT_W'(1);
          // Publish on the last bit so sum/cout are valid alongside done
          if (cnt == LAST_BIT) begin
            sum  <= res_next;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. An 8-bit instance
//                runs directed and random adds; a 4-bit instance runs all
//                operand/carry-in combinations. Expected results come from
//                plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: (a + b + cin) as a WIDTH+1 bit value
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[8:0];
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[4:0];
  endfunction

  // One complete add on the 8-bit instance, with latency and result checks.
  // Operand inputs are scrambled after acceptance to show they are not reused.
  task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] exp;
    int n;
    exp = ref8(a, b, c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    chk({tag, "_busy"}, busy8, 1'b1);
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_sum"}, sum8, exp[7:0]);
    chk({tag, "_cout"}, cout8, exp[8]);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, done8, 1'b0);
  endtask

  task automatic add4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] exp;
    int n;
    exp = ref4(a, b, c);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4_lat", n, 4);
    chk("w4_result", {cout4, sum4}, exp);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int n_done;
    int t_done [2];
    logic [7:0] sum_seen;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] exp;

    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start4 = 1'b1; a4 = 4'hF;  b4 = 4'hF;  cin4 = 1'b1;

    // Reset has priority over start
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", cout8, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    @(negedge clk);
    start8 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy8, 1'b0);

    // Directed adds
    add8("zero", 8'h00, 8'h00, 1'b0);
    add8("wrap", 8'hFF, 8'h01, 1'b0);
    add8("a5_5a", 8'hA5, 8'h5A, 1'b1);
    add8("0f_01", 8'h0F, 8'h01, 1'b0);

    // Start during busy must be ignored
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk); @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_done = 0;
    sum_seen = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        n_done++;
        sum_seen = sum8;
      end
    end
    chk("ign_ndone", n_done, 1);
    chk("ign_sum", sum_seen, 8'h07);
    chk("ign_cout", cout8, 1'b0);
    chk("hold_sum", sum8, 8'h07);

    // Reset in the middle of an add: prior result 0x07 is cleared
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_sum", sum8, 8'h00);
    chk("mid_rst_cout", cout8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) n_done++;
    end
    chk("mid_rst_nodone", n_done, 0);
    add8("after_rst", 8'h12, 8'h34, 1'b0);

    // Random adds
    for (int i = 0; i < 12; i++) begin
      add8("rand", 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Start held high: two accepted ops, done pulses WIDTH+2 apart
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    exp = ref8(ra, rb, rc);
    @(negedge clk);
    a8 = ra; b8 = rb; cin8 = rc; start8 = 1'b1;
    n_done = 0;
    t_done[0] = -1; t_done[1] = -1;
    for (int k = 0; k < 26; k++) begin
      @(posedge clk); #1;
      if (k == 10) start8 = 1'b0;
      if (done8) begin
        if (n_done < 2) t_done[n_done] = k;
        n_done++;
        chk("b2b_result", {cout8, sum8}, exp);
      end
    end
    chk("b2b_ndone", n_done, 2);
    chk("b2b_spacing", t_done[1] - t_done[0], 10);

    // Exhaustive 4-bit operands with both carry-in values
    for (int c = 0; c < 2; c++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          add4(4'(x), 4'(y), 1'(c));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
